// File: rtl/accelerator_sdiv_28s_10ns_seq_pkg.sv
// Shared constants and types for the signed-by-unsigned divider.
// Widths, FSM states and divide-by-zero quotient patterns.
package accelerator_sdiv_pkg;

  localparam int SDIV_DVD_W    = 28;
  localparam int SDIV_DVS_W    = 10;
  localparam int SDIV_NARROW_W = 18;
  localparam int SDIV_REM_W    = 11;
  localparam int SDIV_CNT_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } sdiv_state_t;

  localparam logic [SDIV_DVD_W-1:0] DBZ_POS_Q = 28'h7FF_FFFF;
  localparam logic [SDIV_DVD_W-1:0] DBZ_NEG_Q = 28'h800_0000;

endpackage

// File: rtl/accelerator_sdiv_28s_10ns_seq_if.sv
// Operand/result handshake bundle for the divider.
// master: operand source + result sink; slave: the divider.
interface accelerator_sdiv_28s_10ns_seq_if;
  import accelerator_sdiv_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [SDIV_DVD_W-1:0] dividend;
  logic [SDIV_DVS_W-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [SDIV_DVD_W-1:0] quotient;
  logic [SDIV_REM_W-1:0] remainder;
  logic                  ovf;
  logic                  dbz;
  logic                  busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder,
    input  ovf, dbz, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder,
    output ovf, dbz, busy
  );

endinterface

// File: rtl/accelerator_sdiv_28s_10ns_seq_step.sv
// One radix-2 restoring division step (combinational).
// Ports: prem/din/divisor in; nrem/qbit out.
module accelerator_sdiv_step #(
  parameter int DW = 10
) (
  input  logic [DW:0]   prem,
  input  logic          din,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   nrem,
  output logic          qbit
);

  logic [DW+1:0] sh;
  logic [DW+1:0] dvs_x;

  // One spare top bit so the shifted value never wraps.
  assign sh    = {prem, din};
  assign dvs_x = (DW+2)'(divisor);
  assign qbit  = (sh >= dvs_x);
  assign nrem  = qbit ? (DW+1)'(sh - dvs_x)
                      : sh[DW:0];

endmodule

// File: rtl/accelerator_sdiv_28s_10ns_seq.sv
// Iterative 28s / 10u restoring divider, 1 bit/clock.
// Ports: ap_clk, ap_rst (async high), bus (slave handshake).
module accelerator_sdiv_28s_10ns_seq
  import accelerator_sdiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = SDIV_DVD_W,
  parameter int DIVISOR_WIDTH  = SDIV_DVS_W,
  parameter int NARROW_WIDTH   = SDIV_NARROW_W
) (
  input  logic ap_clk,
  input  logic ap_rst,
  accelerator_sdiv_28s_10ns_seq_if.slave bus
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int RW = DIVISOR_WIDTH + 1;
  localparam int CW = $clog2(DIVIDEND_WIDTH);
  localparam int HW = DW - NARROW_WIDTH + 1;

  sdiv_state_t state;

  logic [DW-1:0]            acc;
  logic [RW-1:0]            prem;
  logic [DIVISOR_WIDTH-1:0] dvs;
  logic                     neg;
  logic                     zero;
  logic [CW-1:0]            cnt;

  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;
  logic [DW-1:0] q_r;
  logic [RW-1:0] r_r;
  logic          ovf_r;
  logic          dbz_r;

  logic [DW-1:0] mag;
  logic [RW-1:0] nrem;
  logic          qbit;
  logic [DW-1:0] q_fix;
  logic [RW-1:0] r_fix;
  logic [HW-1:0] hi;
  logic          ovf_fix;

  // |-2^27| = 2^27 still fits the unsigned 28-bit field.
  assign mag = bus.dividend[DW-1] ? -bus.dividend
                                  : bus.dividend;

  // acc starts as |dividend|; its MSB feeds each step and
  // quotient bits shift in at the bottom.
  accelerator_sdiv_step #(
    .DW (DIVISOR_WIDTH)
  ) u_step (
    .prem    (prem),
    .din     (acc[DW-1]),
    .divisor (dvs),
    .nrem    (nrem),
    .qbit    (qbit)
  );

  // Quotient fits NARROW_WIDTH signed iff the top bits
  // down to the narrow sign bit are all equal.
  always_comb begin
    q_fix   = neg ? -acc : acc;
    r_fix   = neg ? -prem : prem;
    hi      = q_fix[DW-1:NARROW_WIDTH-1];
    ovf_fix = !((&hi) || !(|hi));
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      prem        <= '0;
      dvs         <= '0;
      neg         <= 1'b0;
      zero        <= 1'b0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
      ovf_r       <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            acc        <= mag;
            neg        <= bus.dividend[DW-1];
            dvs        <= bus.divisor;
            zero       <= (bus.divisor == '0);
            prem       <= '0;
            cnt        <= CW'(DW - 1);
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          acc  <= {acc[DW-2:0], qbit};
          prem <= nrem;
          cnt  <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_FIX;
        end
        S_FIX: begin
          if (zero) begin
            q_r   <= neg ? DW'(DBZ_NEG_Q)
                         : DW'(DBZ_POS_Q);
            r_r   <= '0;
            ovf_r <= 1'b1;
            dbz_r <= 1'b1;
          end else begin
            q_r   <= q_fix;
            r_r   <= r_fix;
            ovf_r <= ovf_fix;
            dbz_r <= 1'b0;
          end
          out_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.quotient  = q_r;
  assign bus.remainder = r_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbz       = dbz_r;

endmodule

// File: doc/accelerator_sdiv_28s_10ns_seq.md
Name: accelerator_sdiv_28s_10ns_seq

Overview:
- Iterative signed-by-unsigned divider; the inverse of the accelerator's 18s x 10ns -> 28 multiplier.
- Takes a 28-bit signed product-domain value and a 10-bit unsigned divisor. Returns a 28-bit signed quotient, an 11-bit signed remainder and range flags.
- Sits in the accelerator datapath wherever a scaled product must be de-scaled, e.g. normalisation by a 10-bit gain. Radix-2 restoring algorithm, one quotient bit per clock, valid/ready on both sides.

Parameters:
- DIVIDEND_WIDTH, 28, dividend and quotient width (signed).
- DIVISOR_WIDTH, 10, divisor width (unsigned).
- NARROW_WIDTH, 18, signed width against which ovf is judged (the multiplier's din0 width).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- dividend  in  28  signed dividend.
- divisor  in  10  unsigned divisor.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  downstream accepts result.
- quotient  out  28  signed quotient, truncated toward zero.
- remainder  out  11  signed remainder; sign of dividend.
- ovf  out  1  quotient outside [-2^17, 2^17-1].
- dbz  out  1  divisor was zero.
- busy  out  1  high in CALC or FIX.

Behaviour:
- Reset (async, ap_rst=1):
  - state=IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - quotient, remainder, ovf and dbz are all 0.
  - Any in-flight operation is discarded with no output produced.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE) only.
- IDLE: on an edge with in_valid=1, the block:
  - latches |dividend| as 28-bit unsigned (|-2^27| = 2^27 fits), the dividend sign, divisor, and divisor==0;
  - clears partial remainder (11 bits);
  - sets count=DIVIDEND_WIDTH-1 and goes to CALC.
- CALC, each edge, one restoring step MSB-first:
  - shift the next dividend bit into the partial remainder;
  - if the shifted remainder >= divisor, subtract and set the quotient bit to 1, else set it to 0;
  - decrement count; after the step with count==0, go to FIX.
  - Exactly DIVIDEND_WIDTH edges are spent in CALC regardless of operands.
- FIX, one edge:
  - negate the quotient if the dividend was negative;
  - negate the remainder if the dividend was negative;
  - compute ovf and register all outputs;
  - set out_valid=1 and go to DONE.
- Latency: operands accepted at edge k give out_valid=1 after edge k+29.
- DONE:
  - outputs are held stable while out_ready=0;
  - on an edge with out_valid & out_ready, out_valid goes to 0 and the state returns to IDLE;
  - in_ready rises in the next cycle, with no overlap of consumption and acceptance;
  - minimum initiation interval is 31 cycles.
- Arithmetic rules:
  - dividend == quotient*divisor + remainder exactly;
  - |remainder| < divisor;
  - remainder is 0 or carries the dividend's sign;
  - quotient always fits 28-bit signed (range -2^27 .. 2^27-1).
- Divisor = 0:
  - full CALC latency is kept;
  - FIX overrides quotient to 0x7FFFFFF if dividend >= 0, else 0x8000000;
  - remainder=0, dbz=1, ovf=1.
- ovf is informational only; the quotient is never saturated except on dbz.
- While not in IDLE, in_valid is ignored and the operand inputs may change freely.
- Reset asserted mid-CALC or in DONE returns to the reset state immediately (async); the result is lost.

Decomposition:
- Package accelerator_sdiv_pkg holds:
  - width constants: 28, 10, 18, remainder width 11, count width 5;
  - state enum (IDLE/CALC/FIX/DONE);
  - DBZ_POS_Q and DBZ_NEG_Q constants.
- One combinational sub-module, accelerator_sdiv_step:
  - inputs: partial remainder, next dividend bit, divisor;
  - outputs: new remainder and quotient bit.
  - It is reused if the team later moves to an unrolled or radix-4 variant.
- The FSM, counter and sign fix stay in the top.

Test Plan:
- 1000 / 7 -> quotient=142, remainder=6, ovf=0, dbz=0; out_valid first high after edge k+29.
- -1000 / 7 -> quotient=-142, remainder=-6; 131071 / 1 -> quotient=131071, ovf=0; 131072 / 1 -> ovf=1.
- -134217728 / 1 -> quotient=-134217728, remainder=0, ovf=1; 5 / 1023 -> quotient=0, remainder=5.
- 12345 / 0 -> quotient=0x7FFFFFF, remainder=0, dbz=1, ovf=1; -1 / 0 -> quotient=0x8000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid:
  - outputs stay stable and in_ready stays 0;
  - in_valid pulses during the hold are ignored;
  - after release, in_ready rises the following cycle.
- Reset mid-operation, then 2000 random signed-dividend/unsigned-divisor pairs:
  - assert ap_rst asynchronously at CALC step 10 -> all outputs are 0 at once and in_ready=1 after deassert; the next operation completes correctly.
  - for each random pair, check dividend == quotient*divisor + remainder using the multiplier's widths, and check the remainder bound and sign rule.
